// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for the data-memory port arbiter: the CPU data bus, the single
// memory port and the screen-word stream towards the display serializer.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
);
  // CPU data bus
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_adr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ready;
  logic [DATA_W-1:0] cpu_rdata;
  // shared memory port
  logic              mem_load;
  logic [ADDR_W-1:0] mem_adr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;
  // screen word stream
  logic              vid_enable;
  logic              vid_valid;
  logic              vid_ready;
  logic [DATA_W-1:0] vid_data;
  logic [12:0]       vid_idx;
  logic              vid_frame_start;

  // arbiter side
  modport slave (
    input  cpu_req, cpu_we, cpu_adr, cpu_wdata, mem_dout, vid_enable, vid_ready,
    output cpu_ready, cpu_rdata, mem_load, mem_adr, mem_din,
           vid_valid, vid_data, vid_idx, vid_frame_start
  );

  // environment side (CPU, memory, display)
  modport master (
    output cpu_req, cpu_we, cpu_adr, cpu_wdata, mem_dout, vid_enable, vid_ready,
    input  cpu_ready, cpu_rdata, mem_load, mem_adr, mem_din,
           vid_valid, vid_data, vid_idx, vid_frame_start
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the single data-memory port between the CPU and the video scan
// engine. The CPU has priority, but video is never denied more than MAX_WAIT
// consecutive cycles while it wants a word. The scan engine walks the screen
// region one word per grant and inserts a blanking gap between frames.
module mem_port_arbiter #(
  parameter int ADDR_W       = 15,
  parameter int DATA_W       = 16,
  parameter int SCREEN_BASE  = 16384,
  parameter int SCREEN_WORDS = 8192,
  parameter int BLANK_CYCLES = 64,
  parameter int MAX_WAIT     = 4
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus
);

  localparam int IDX_W  = 13;
  localparam int BLK_W  = $clog2(BLANK_CYCLES + 1);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {ST_OFF, ST_SCAN, ST_BLANK} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [BLK_W-1:0]    blank_q, blank_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                vid_valid_q, vid_valid_d;
  logic [DATA_W-1:0]   vid_data_q, vid_data_d;
  logic [IDX_W-1:0]    vid_idx_q, vid_idx_d;

  logic vid_want;
  logic vid_gnt;
  logic cpu_gnt;

  // Per-cycle arbitration: video only wins against a CPU request once its wait budget is spent
  always_comb begin
    vid_want = (state_q == ST_SCAN) && (!vid_valid_q || bus.vid_ready);
    vid_gnt  = vid_want && (!bus.cpu_req || (wait_q == WAIT_W'(MAX_WAIT)));
    cpu_gnt  = bus.cpu_req && !vid_gnt;
  end

  // Memory port steering; reset suppresses CPU handshakes and writes
  always_comb begin
    bus.mem_load  = 1'b0;
    bus.mem_adr   = '0;
    bus.mem_din   = bus.cpu_wdata;
    bus.cpu_ready = 1'b0;
    bus.cpu_rdata = bus.mem_dout;
    if (vid_gnt) begin
      bus.mem_adr = ADDR_W'(SCREEN_BASE) + ADDR_W'(ptr_q);
    end else if (cpu_gnt) begin
      bus.mem_adr   = bus.cpu_adr;
      bus.mem_load  = bus.cpu_we && !reset;
      bus.cpu_ready = !reset;
    end
  end

  // Scan FSM, wait counter and output word register next-state
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    blank_d     = blank_q;
    wait_d      = wait_q;
    vid_valid_d = vid_valid_q;
    vid_data_d  = vid_data_q;
    vid_idx_d   = vid_idx_q;

    if (!vid_want || vid_gnt) begin
      wait_d = '0;
    end else if (wait_q != WAIT_W'(MAX_WAIT)) begin
      wait_d = wait_q + 1'b1;
    end

    // a fetch refills the word register; otherwise acceptance empties it
    if (vid_gnt) begin
      vid_valid_d = 1'b1;
      vid_data_d  = bus.mem_dout;
      vid_idx_d   = ptr_q;
    end else if (vid_valid_q && bus.vid_ready) begin
      vid_valid_d = 1'b0;
    end

    case (state_q)
      ST_OFF: begin
        ptr_d   = '0;
        blank_d = '0;
        if (bus.vid_enable) state_d = ST_SCAN;
      end
      ST_SCAN: begin
        if (vid_gnt) begin
          if (ptr_q == IDX_W'(SCREEN_WORDS - 1)) begin
            ptr_d   = '0;
            state_d = ST_BLANK;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
      ST_BLANK: begin
        if (blank_q == BLK_W'(BLANK_CYCLES - 1)) begin
          blank_d = '0;
          state_d = ST_SCAN;
        end else begin
          blank_d = blank_q + 1'b1;
        end
      end
      default: state_d = ST_OFF;
    endcase

    // disabling drops any pending word and restarts the frame from index 0
    if (!bus.vid_enable) begin
      state_d     = ST_OFF;
      ptr_d       = '0;
      blank_d     = '0;
      vid_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_OFF;
      ptr_q       <= '0;
      blank_q     <= '0;
      wait_q      <= '0;
      vid_valid_q <= 1'b0;
      vid_data_q  <= '0;
      vid_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      blank_q     <= blank_d;
      wait_q      <= wait_d;
      vid_valid_q <= vid_valid_d;
      vid_data_q  <= vid_data_d;
      vid_idx_q   <= vid_idx_d;
    end
  end

  assign bus.vid_valid       = vid_valid_q;
  assign bus.vid_data        = vid_data_q;
  assign bus.vid_idx         = vid_idx_q;
  assign bus.vid_frame_start = vid_valid_q && (vid_idx_q == '0);

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Single-port arbiter and sequencer for the 24576-word data memory. It shares the memory's one address and write port between the CPU data bus and a video scan engine. The scan engine streams the 8192-word screen region (base 16384) word by word to the display path, with a vertical-blank gap between frames. The block sits between the CPU, the data memory and the display serializer. The CPU has priority, but a bounded-wait rule guarantees the scan engine forward progress.

## Interface
Parameters:
- ADDR_W, 15, memory address width
- DATA_W, 16, memory word width
- SCREEN_BASE, 16384, first screen word address
- SCREEN_WORDS, 8192, words per frame (power of two)
- BLANK_CYCLES, 64, idle cycles between frames (≥1)
- MAX_WAIT, 4, max consecutive cycles video may be denied while wanting (≥1)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- cpu_req  in  1  CPU access request (held until cpu_ready)
- cpu_we  in  1  1=write, 0=read
- cpu_adr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ready  out  1  CPU access performed this cycle
- cpu_rdata  out  DATA_W  read data, valid when cpu_ready && !cpu_we
- mem_load  out  1  memory write enable
- mem_adr  out  ADDR_W  memory address
- mem_din  out  DATA_W  memory write data
- mem_dout  in  DATA_W  memory read data, combinational from mem_adr
- vid_enable  in  1  scan engine enable
- vid_valid  out  1  vid_data holds an unconsumed screen word
- vid_ready  in  1  display accepts word
- vid_data  out  DATA_W  screen word
- vid_idx  out  13  word index of vid_data within the frame
- vid_frame_start  out  1  high with vid_valid for index 0

## Operation
- Scan FSM states:
  - OFF: no fetches; fetch pointer = 0.
  - SCAN: fetch words 0..SCREEN_WORDS-1.
  - BLANK: count BLANK_CYCLES, then return to SCAN with pointer 0.
- Transitions:
  - OFF→SCAN when vid_enable = 1.
  - SCAN→BLANK on the grant of word SCREEN_WORDS-1.
  - Any state→OFF when vid_enable = 0. The pointer and blank counter clear, and vid_valid clears next edge; a pending word is dropped.
- vid_want = state==SCAN && (!vid_valid || vid_ready).
- Arbitration, per cycle and combinational:
  - Video wins if vid_want && (!cpu_req || wait_cnt == MAX_WAIT).
  - Otherwise the CPU wins if cpu_req.
- wait_cnt:
  - Increments when vid_want && not granted.
  - Clears on a video grant or when !vid_want.
  - Saturates at MAX_WAIT.
- CPU grant:
  - mem_adr = cpu_adr, mem_load = cpu_we, mem_din = cpu_wdata, cpu_ready = 1, cpu_rdata = mem_dout.
- Video grant:
  - mem_adr = SCREEN_BASE + pointer, mem_load = 0, cpu_ready = 0.
  - mem_dout registers into vid_data and vid_idx = pointer, vid_valid = 1 at the next edge, and the pointer increments.
- No grant: mem_load = 0, mem_adr = 0.
- Output word register:
  - Cleared when vid_valid && vid_ready and no new fetch is granted.
  - Overwritten only via a fetch, which requires an empty register or acceptance in the same cycle.
- CPU writes to the screen region are not interlocked with scanning. The new value appears on the next frame, or this frame if the word is not yet fetched.

## Timing
- While reset is asserted, the combinational outputs are forced to cpu_ready = 0 and mem_load = 0.
- After reset: state OFF, pointer 0, wait_cnt 0, vid_valid 0, vid_data 0, vid_idx 0, vid_frame_start 0. Reset mid-frame takes the same values; no memory write occurs in a reset cycle.
- CPU latency: 0 cycles when granted (same-cycle cpu_ready, write on that edge). The worst case is 1 stalled cycle per MAX_WAIT+1 cycles under contention.
- Video latency: grant in cycle N → vid_valid in cycle N+1.
- Sustained throughput with vid_ready held high and no CPU traffic is 1 word per cycle. The first word appears 2 cycles after vid_enable rises: the OFF→SCAN edge, then the fetch.
- Frame period with no contention and vid_ready = 1: SCREEN_WORDS + BLANK_CYCLES cycles.
- The pointer wraps from SCREEN_WORDS-1 to 0 only via BLANK.
- vid_frame_start = vid_valid && vid_idx == 0.

## Test plan
- Reset: assert reset with cpu_req=1 and cpu_we=1 → mem_load=0 and cpu_ready=0. After release, all outputs equal their reset values.
- CPU only, vid_enable=0:
  - Write 0x1234 to address 5 → cpu_ready and mem_load the same cycle.
  - Read address 5 → cpu_rdata=0x1234 with cpu_ready=1.
- Video only, vid_ready=1, BLANK_CYCLES=64 → words idx 0..8191 from addresses 16384..24575 on consecutive cycles. vid_frame_start is high on idx 0, then there is a 64-cycle gap and the frame restarts.
- Contention, MAX_WAIT=4, cpu_req held high, vid_enable=1 → pattern of 4 cpu_ready cycles followed by 1 stall cycle with a video fetch, repeating.
- Backpressure: vid_ready=0 for 10 cycles → vid_data/vid_idx stable, no video fetch, and the CPU is granted every cycle. After release, idx continues without a gap or repeat.
- Disable mid-frame at idx 100 → vid_valid=0 next cycle. On re-enable, the first word is idx 0 with vid_frame_start=1.
